// File: rtl/regbank_pkg.sv
// Shared widths and types for the register bank with busy-bit scoreboard.
package regbank_pkg;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 4;
  localparam int DEPTH  = 2 ** ADDR_W;

  typedef logic [ADDR_W-1:0] reg_addr_t;
  typedef logic [DATA_W-1:0] reg_data_t;
  typedef logic [DEPTH-1:0]  busy_vec_t;

  localparam reg_addr_t ZERO_ADDR = {ADDR_W{1'b0}};

endpackage

// File: rtl/register_bank_sb_if.sv
// Decode/write-back bus of the register bank: read ports, write port, issue port, stall.
interface register_bank_sb_if;
  import regbank_pkg::*;

  reg_addr_t RA1;
  reg_addr_t RA2;
  reg_data_t RD1;
  reg_data_t RD2;
  logic      WE;
  reg_addr_t WA;
  reg_data_t WD;
  logic      SetBusy;
  reg_addr_t SetAddr;
  logic      Stall;
  busy_vec_t BusyVec;

  modport master (
    output RA1, RA2, WE, WA, WD, SetBusy, SetAddr,
    input  RD1, RD2, Stall, BusyVec
  );

  modport slave (
    input  RA1, RA2, WE, WA, WD, SetBusy, SetAddr,
    output RD1, RD2, Stall, BusyVec
  );

endinterface

// File: rtl/regbank_scoreboard.sv
// Busy-bit scoreboard: issue sets, write-back clears (issue wins on a tie), Stall on busy reads.
// REG_BANK_BYPASS_EN: a same-cycle write to a read address resolves its busy bit.
module regbank_scoreboard
  import regbank_pkg::*;
#(
  parameter int ZERO_REG = 1
) (
  input  logic      CLK,
  input  logic      Reset,
  input  logic      WE,
  input  reg_addr_t WA,
  input  logic      SetBusy,
  input  reg_addr_t SetAddr,
  input  reg_addr_t RA1,
  input  reg_addr_t RA2,
  output logic      Stall,
  output busy_vec_t BusyVec
);

  localparam bit ZERO_EN = (ZERO_REG != 32'sd0);

  busy_vec_t busy_r;
  busy_vec_t busy_nxt_s;
  logic      set_ok_s;
  logic      clr_ok_s;
  logic      resolved1_s;
  logic      resolved2_s;

  // Next busy bits: clear on write-back, then a new producer overrides the clear.
  always_comb begin
    busy_nxt_s = busy_r;
    set_ok_s   = SetBusy && !(ZERO_EN && (SetAddr == ZERO_ADDR));
    clr_ok_s   = WE && !(ZERO_EN && (WA == ZERO_ADDR));
    if (clr_ok_s) begin
      busy_nxt_s[WA] = 1'b0;
    end else begin
      busy_nxt_s = busy_nxt_s;
    end
    if (set_ok_s) begin
      busy_nxt_s[SetAddr] = 1'b1;
    end else begin
      busy_nxt_s = busy_nxt_s;
    end
  end

  // Busy-bit storage with synchronous reset.
  always_ff @(posedge CLK) begin
    if (Reset) begin
      busy_r <= {DEPTH{1'b0}};
    end else begin
      busy_r <= busy_nxt_s;
    end
  end

  // Per-port resolution and the stall request.
  always_comb begin
`ifdef REG_BANK_BYPASS_EN
    resolved1_s = clr_ok_s && (WA == RA1);
    resolved2_s = clr_ok_s && (WA == RA2);
`else
    resolved1_s = 1'b0;
    resolved2_s = 1'b0;
`endif
    Stall = (busy_r[RA1] && !resolved1_s) || (busy_r[RA2] && !resolved2_s);
  end

  assign BusyVec = busy_r;

endmodule

// File: rtl/register_bank_sb.sv
// 16 x 32 register bank with two combinational read ports, one write port and a busy scoreboard.
// REG_BANK_BYPASS_EN: write-first forwarding of WD to a read port addressing WA.
module register_bank_sb
  import regbank_pkg::*;
#(
  parameter int ZERO_REG = 1
) (
  input logic               CLK,
  input logic               Reset,
  register_bank_sb_if.slave bus
);

  localparam bit ZERO_EN = (ZERO_REG != 32'sd0);

  reg_data_t regs_r [DEPTH];
  logic      wr_ok_s;
  reg_data_t rd1_s;
  reg_data_t rd2_s;

  assign wr_ok_s = bus.WE && !(ZERO_EN && (bus.WA == ZERO_ADDR));

  // Data array; writes to the hardwired zero register are dropped.
  always_ff @(posedge CLK) begin
    if (Reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs_r[i] <= {DATA_W{1'b0}};
      end
    end else if (wr_ok_s) begin
      regs_r[bus.WA] <= bus.WD;
    end else begin
      regs_r[bus.WA] <= regs_r[bus.WA];
    end
  end

  // Read muxes: zero register first, then optional forwarding, else stored value.
  always_comb begin
    rd1_s = regs_r[bus.RA1];
    rd2_s = regs_r[bus.RA2];
    if (ZERO_EN && (bus.RA1 == ZERO_ADDR)) begin
      rd1_s = {DATA_W{1'b0}};
`ifdef REG_BANK_BYPASS_EN
    end else if (wr_ok_s && (bus.WA == bus.RA1)) begin
      rd1_s = bus.WD;
`endif
    end else begin
      rd1_s = regs_r[bus.RA1];
    end
    if (ZERO_EN && (bus.RA2 == ZERO_ADDR)) begin
      rd2_s = {DATA_W{1'b0}};
`ifdef REG_BANK_BYPASS_EN
    end else if (wr_ok_s && (bus.WA == bus.RA2)) begin
      rd2_s = bus.WD;
`endif
    end else begin
      rd2_s = regs_r[bus.RA2];
    end
  end

  assign bus.RD1 = rd1_s;
  assign bus.RD2 = rd2_s;

  regbank_scoreboard #(
    .ZERO_REG (ZERO_REG)
  ) u_scoreboard (
    .CLK     (CLK),
    .Reset   (Reset),
    .WE      (bus.WE),
    .WA      (bus.WA),
    .SetBusy (bus.SetBusy),
    .SetAddr (bus.SetAddr),
    .RA1     (bus.RA1),
    .RA2     (bus.RA2),
    .Stall   (bus.Stall),
    .BusyVec (bus.BusyVec)
  );

endmodule
